// File: rtl/vector_packer_pkg.sv
// ============================================================================
// Module      : vector_packer_pkg
// Description : Shared definitions for the vector datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vector_packer_pkg;

    localparam int VP_VECTOR_SIZE = 8;
    localparam int VP_DATA_WIDTH  = 32;

    localparam logic [VP_VECTOR_SIZE*VP_DATA_WIDTH-1:0] VP_ZERO_VEC = '0;

    // A single-lane vector still needs a one-bit index register.
    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vector_hold_reg.sv
// ============================================================================
// Module      : vector_hold_reg
// Description : Output vector register with load/consume handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_hold_reg #(
    parameter int VECTOR_SIZE = 8,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_load,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] i_data,
    input  logic [VECTOR_SIZE-1:0]            i_mask,
    input  logic                              i_last,
    input  logic                              i_ready,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] o_data,
    output logic [VECTOR_SIZE-1:0]            o_valid,
    output logic                              o_last,
    output logic                              o_free
);

    logic [VECTOR_SIZE*DATA_WIDTH-1:0] r_data;
    logic [VECTOR_SIZE-1:0]            r_valid;
    logic                              r_last;

    assign o_free  = (r_valid == '0) || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= i_mask;
            r_last  <= i_last;
        end else if ((r_valid != '0) && i_ready) begin
            r_data  <= '0;
            r_valid <= '0;
            r_last  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vector_packer.sv
// ============================================================================
// Module      : vector_packer
// Description : Packs a scalar word stream into masked multi-lane vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_packer
    import vector_packer_pkg::*;
#(
    parameter int VECTOR_SIZE = 8,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clkIn,
    input  logic                              rstIn,
    input  logic [DATA_WIDTH-1:0]             dataIn,
    input  logic                              validIn,
    input  logic                              lastIn,
    output logic                              readyOut,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataOut,
    output logic [VECTOR_SIZE-1:0]            validOut,
    output logic                              lastOut,
    input  logic                              readyIn
);

    localparam int LANE_W = lane_idx_width(VECTOR_SIZE);
    localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(VECTOR_SIZE - 1);

    logic [VECTOR_SIZE*DATA_WIDTH-1:0] r_asm;
    logic [VECTOR_SIZE-1:0]            r_mask;
    logic                              r_last;
    logic [LANE_W-1:0]                 r_lane;
    logic                              r_pending;

    logic [VECTOR_SIZE*DATA_WIDTH-1:0] w_next_asm;
    logic [VECTOR_SIZE-1:0]            w_next_mask;
    logic                              w_accept;
    logic                              w_complete;
    logic                              w_free;
    logic                              w_load;
    logic [VECTOR_SIZE*DATA_WIDTH-1:0] w_load_data;
    logic [VECTOR_SIZE-1:0]            w_load_mask;
    logic                              w_load_last;

    assign readyOut   = !r_pending;
    assign w_accept   = validIn && !r_pending;
    assign w_complete = w_accept && ((r_lane == C_LAST_LANE) || lastIn);

    always_comb begin
        w_next_asm  = r_asm;
        w_next_mask = r_mask;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_next_asm[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = dataIn;
                w_next_mask[i] = 1'b1;
            end
        end
    end

    // A pending vector and a fresh completion are mutually exclusive,
    // because readyOut is low for as long as a vector is pending.
    assign w_load      = (r_pending || w_complete) && w_free;
    assign w_load_data = r_pending ? r_asm  : w_next_asm;
    assign w_load_mask = r_pending ? r_mask : w_next_mask;
    assign w_load_last = r_pending ? r_last : lastIn;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            r_asm     <= '0;
            r_mask    <= '0;
            r_last    <= 1'b0;
            r_lane    <= '0;
            r_pending <= 1'b0;
        end else if (r_pending) begin
            if (w_free) begin
                r_asm     <= '0;
                r_mask    <= '0;
                r_last    <= 1'b0;
                r_pending <= 1'b0;
            end
        end else if (w_complete) begin
            r_lane <= '0;
            if (w_free) begin
                r_asm  <= '0;
                r_mask <= '0;
                r_last <= 1'b0;
            end else begin
                r_asm     <= w_next_asm;
                r_mask    <= w_next_mask;
                r_last    <= lastIn;
                r_pending <= 1'b1;
            end
        end else if (w_accept) begin
            r_asm  <= w_next_asm;
            r_mask <= w_next_mask;
            r_lane <= r_lane + 1'b1;
        end
    end

    vector_hold_reg #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_hold (
        .clk     (clkIn),
        .rst_n   (rstIn),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_mask  (w_load_mask),
        .i_last  (w_load_last),
        .i_ready (readyIn),
        .o_data  (dataOut),
        .o_valid (validOut),
        .o_last  (lastOut),
        .o_free  (w_free)
    );

endmodule

`default_nettype wire

// File: tb/tb_vector_packer.sv
// ============================================================================
// Module      : tb_vector_packer
// Description : Directed and randomized self-checking bench for vector_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_packer;

    localparam int VS = 8;
    localparam int DW = 32;

    typedef struct {
        logic [VS*DW-1:0] d;
        logic [VS-1:0]    m;
        logic             l;
    } vec_t;

    logic             clk;
    logic             rstIn;
    logic [DW-1:0]    dataIn;
    logic             validIn;
    logic             lastIn;
    logic             readyOut;
    logic [VS*DW-1:0] dataOut;
    logic [VS-1:0]    validOut;
    logic             lastOut;
    logic             readyIn;

    int n_cmp;
    int n_err;
    int stalls;

    vec_t exp_q[$];
    vec_t got_q[$];

    logic [DW-1:0] m_data[VS];
    logic [VS-1:0] m_mask;
    int            m_lane;

    vector_packer #(.VECTOR_SIZE(VS), .DATA_WIDTH(DW)) dut (
        .clkIn    (clk),
        .rstIn    (rstIn),
        .dataIn   (dataIn),
        .validIn  (validIn),
        .lastIn   (lastIn),
        .readyOut (readyOut),
        .dataOut  (dataOut),
        .validOut (validOut),
        .lastOut  (lastOut),
        .readyIn  (readyIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output beats are captured mid-cycle, before the edge that consumes them.
    always @(negedge clk) begin
        if (rstIn && (validOut != '0) && readyIn) begin
            vec_t v;
            v.d = dataOut;
            v.m = validOut;
            v.l = lastOut;
            got_q.push_back(v);
        end
    end

    task automatic chk(input string tag, input logic [VS*DW-1:0] got, input logic [VS*DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < VS; i++) m_data[i] = '0;
        m_mask = '0;
        m_lane = 0;
    endtask

    task automatic model_word(input logic [DW-1:0] d, input logic l);
        vec_t v;
        m_data[m_lane] = d;
        m_mask[m_lane] = 1'b1;
        if (m_lane == VS - 1 || l) begin
            for (int i = 0; i < VS; i++) v.d[i*DW +: DW] = m_data[i];
            v.m = m_mask;
            v.l = l;
            exp_q.push_back(v);
            model_reset();
        end else begin
            m_lane++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        validIn = 1'b0;
        lastIn  = 1'b0;
    endtask

    // Leaves validIn high so consecutive calls stream without bubbles.
    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int waited;
        waited  = 0;
        validIn = 1'b1;
        dataIn  = d;
        lastIn  = l;
        while (!readyOut && waited < 200) begin
            stalls++;
            tick();
            waited++;
        end
        if (waited >= 200) begin
            chk("accept_timeout", 256'd0, 256'd1);
        end else begin
            tick();
            model_word(d, l);
        end
    endtask

    task automatic check_sb(input string tag);
        int sz;
        idle();
        readyIn = 1'b1;
        for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) tick();
        tick();
        chk({tag, "_count"}, 256'(got_q.size()), 256'(exp_q.size()));
        sz = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < sz; i++) begin
            chk({tag, "_data"}, got_q[i].d, exp_q[i].d);
            chk({tag, "_mask"}, 256'(got_q[i].m), 256'(exp_q[i].m));
            chk({tag, "_last"}, 256'(got_q[i].l), 256'(exp_q[i].l));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic done;
        int   plen;
        int   wcnt;
        n_cmp   = 0;
        n_err   = 0;
        stalls  = 0;
        rstIn   = 1'b0;
        dataIn  = '0;
        validIn = 1'b0;
        lastIn  = 1'b0;
        readyIn = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_readyOut", 256'(readyOut), 256'd1);
        chk("rst_validOut", 256'(validOut), 256'd0);
        chk("rst_dataOut",  dataOut,        256'd0);
        chk("rst_lastOut",  256'(lastOut),  256'd0);
        rstIn   = 1'b1;
        readyIn = 1'b1;
        tick();

        // Full packet 1..8, vector visible right after the last word's edge
        for (int i = 1; i <= 8; i++) send_word(DW'(i), i == 8);
        chk("full_valid", 256'(validOut), 256'hFF);
        chk("full_data",  dataOut, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        chk("full_last",  256'(lastOut), 256'd1);
        check_sb("full");

        // Short packet
        send_word(32'hA, 1'b0);
        send_word(32'hB, 1'b0);
        send_word(32'hC, 1'b1);
        chk("short_valid", 256'(validOut), 256'h07);
        chk("short_data",  dataOut, {160'd0, 32'hC, 32'hB, 32'hA});
        chk("short_last",  256'(lastOut), 256'd1);
        check_sb("short");

        // Streaming 20 words with no stalls
        stalls = 0;
        for (int i = 1; i <= 20; i++) send_word(DW'(i), i == 20);
        chk("stream_stalls", 256'(stalls), 256'd0);
        check_sb("stream");

        // Backpressure: second vector completes while first is held
        readyIn = 1'b0;
        for (int i = 1; i <= 16; i++) send_word(DW'(i), 1'b0);
        idle();
        chk("bp_readyOut", 256'(readyOut), 256'd0);
        chk("bp_valid",    256'(validOut), 256'hFF);
        chk("bp_data",     dataOut, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        repeat (3) tick();
        chk("bp_hold_readyOut", 256'(readyOut), 256'd0);
        chk("bp_hold_data",     dataOut, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        check_sb("bp");
        chk("bp_readyOut_after", 256'(readyOut), 256'd1);

        // Reset mid-packet drops the partial vector
        for (int i = 1; i <= 5; i++) send_word(DW'(i), 1'b0);
        idle();
        rstIn = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(validOut), 256'd0);
        model_reset();
        tick();
        rstIn = 1'b1;
        tick();
        send_word(32'h55, 1'b1);
        chk("mid_valid", 256'(validOut), 256'h01);
        chk("mid_data",  dataOut, 256'h55);
        chk("mid_last",  256'(lastOut), 256'd1);
        check_sb("mid");

        // Randomized valid gaps, packet lengths and downstream ready
        done = 1'b0;
        fork
            begin
                wcnt = 0;
                for (int p = 0; p < 12; p++) begin
                    plen = $urandom_range(1, 19);
                    for (int w = 0; w < plen; w++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            idle();
                            repeat ($urandom_range(1, 3)) tick();
                        end
                        wcnt++;
                        send_word(DW'($urandom), w == plen - 1);
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    readyIn = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        check_sb("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
